// File: rtl/t_flip_flop_if.sv
// Signal bundle for a bank of WIDTH toggle flip-flops: the toggle enables plus
// the registered state and its complement.
interface t_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;

    modport master (output t, input q, input q_bar);
    modport slave  (input t, output q, output q_bar);
endinterface

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops with synchronous active-high reset.
// Each bit inverts on a rising clk edge when its t bit is set; q_bar is ~q.
module t_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);
    // One register per bit so no logic is shared between lanes.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_ff @(posedge clk) begin
            if (rst)       q[i] <= RST_VAL[i];
            else if (t[i]) q[i] <= ~q[i];
        end
    end

    assign q_bar = ~q;
endmodule

// File: tb/tb_t_flip_flop.sv
// Directed checks of the toggle flip-flop: a 1-bit instance, a 4-bit instance
// with zero reset value and a 4-bit instance with a non-zero reset value.
module tb_t_flip_flop;
    logic clk = 1'b0;
    logic rst1, rst4;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    t_flip_flop_if #(.WIDTH(1)) w1 ();
    t_flip_flop_if #(.WIDTH(4)) w4 ();
    t_flip_flop_if #(.WIDTH(4)) w4r ();

    t_flip_flop #(.WIDTH(1)) u_w1 (
        .t(w1.t), .clk(clk), .rst(rst1), .q(w1.q), .q_bar(w1.q_bar));
    t_flip_flop #(.WIDTH(4)) u_w4 (
        .t(w4.t), .clk(clk), .rst(rst4), .q(w4.q), .q_bar(w4.q_bar));
    t_flip_flop #(.WIDTH(4), .RST_VAL(4'b0101)) u_w4r (
        .t(w4r.t), .clk(clk), .rst(rst4), .q(w4r.q), .q_bar(w4r.q_bar));

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic e);
        chk({tag, ".q"},     {3'b0, w1.q},     {3'b0, e});
        chk({tag, ".q_bar"}, {3'b0, w1.q_bar}, {3'b0, ~e});
    endtask

    initial begin
        // Reset wins over an active toggle.
        rst1 = 1'b1; rst4 = 1'b1;
        w1.t = 1'b1; w4.t = 4'b1010; w4r.t = 4'b0011;
        tick();
        chk1("rst", 1'b0);
        chk("w4.rst.q",      w4.q,      4'b0000);
        chk("w4.rst.q_bar",  w4.q_bar,  4'b1111);
        chk("w4r.rst.q",     w4r.q,     4'b0101);
        chk("w4r.rst.q_bar", w4r.q_bar, 4'b1010);

        // Hold with t=0 for two edges.
        rst1 = 1'b0; w1.t = 1'b0;
        tick(); chk1("hold0", 1'b0);
        tick(); chk1("hold1", 1'b0);

        // Toggle for three edges, then hold.
        w1.t = 1'b1;
        tick(); chk1("tog0", 1'b1);
        tick(); chk1("tog1", 1'b0);
        tick(); chk1("tog2", 1'b1);
        w1.t = 1'b0;
        tick(); chk1("hold2", 1'b1);

        // Mid-stream reset with t=1: no change until the edge.
        rst1 = 1'b1; w1.t = 1'b1;
        #1 chk1("rst_pre_edge", 1'b1);
        tick(); chk1("rst_mid", 1'b0);

        // Release with t=1 already present: first toggle on first rst=0 edge.
        rst1 = 1'b0;
        #1 chk1("rel_pre_edge", 1'b0);
        tick(); chk1("rel0", 1'b1);
        // t change between edges has no effect until the next edge.
        w1.t = 1'b0; #2 w1.t = 1'b1; #1 w1.t = 1'b0;
        tick(); chk1("glitch_t", 1'b1);

        // 4-bit banks: independent bits, no carry.
        rst4 = 1'b0;
        tick();
        chk("w4.e0.q",      w4.q,      4'b1010);
        chk("w4.e0.q_bar",  w4.q_bar,  4'b0101);
        chk("w4r.e0.q",     w4r.q,     4'b0110);
        chk("w4r.e0.q_bar", w4r.q_bar, 4'b1001);
        tick();
        chk("w4.e1.q",      w4.q,      4'b0000);
        chk("w4.e1.q_bar",  w4.q_bar,  4'b1111);
        chk("w4r.e1.q",     w4r.q,     4'b0101);
        chk("w4r.e1.q_bar", w4r.q_bar, 4'b1010);
        w4.t = 4'b0001; w4r.t = 4'b1000;
        tick();
        chk("w4.e2.q",  w4.q,  4'b0001);
        chk("w4r.e2.q", w4r.q, 4'b1101);
        w4.t = 4'b1111; w4r.t = 4'b1111;
        tick();
        chk("w4.e3.q",      w4.q,      4'b1110);
        chk("w4.e3.q_bar",  w4.q_bar,  4'b0001);
        chk("w4r.e3.q",     w4r.q,     4'b0010);
        // Reset from a non-reset state restores each bank's own value.
        rst4 = 1'b1;
        tick();
        chk("w4.rst2.q",  w4.q,  4'b0000);
        chk("w4r.rst2.q", w4r.q, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
